// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller.
package stopwatch_pkg;

  localparam int         DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  // 2'b11 is unused; the FSM sends it back to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// One decade counter (0..9) with synchronous clear and a ripple-style carry
// that is only asserted while the digit is enabled and sitting at nine.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic               clk_in,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  output logic [DIGIT_W-1:0] q,
  output logic               carry_out
);

  assign carry_out = en & (q == BCD_MAX);

  // Decade count; any value at or above nine rolls back to zero.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= (q >= BCD_MAX) ? '0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: turns rising edges of the divided clock into ticks
// and counts them in cascaded BCD digits under start/stop, clear and lap.
//
//   state | meaning
//   IDLE  | cleared, waiting for the first start
//   RUN   | counting ticks
//   PAUSE | holding the count, waiting for resume
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic                          clk_in,
  input  logic                          rst,
  input  logic                          div_clk,
  input  logic                          start_stop,
  input  logic                          clear,
  input  logic                          lap,
  output logic [DIGIT_W*NUM_DIGITS-1:0] bcd_out,
  output logic                          running,
  output logic                          lap_active,
  output logic                          overflow
);

  logic div_q, div_prev, ss_q, ss_prev, lap_q, lap_prev;
  logic tick, ss_evt, lap_evt;
  state_t state, state_nxt;
  logic [DIGIT_W*NUM_DIGITS-1:0] count, snapshot;
  logic [NUM_DIGITS:0]           en_chain;

  assign tick    = div_q & ~div_prev;
  assign ss_evt  = ss_q & ~ss_prev;
  assign lap_evt = lap_q & ~lap_prev;

  // Two-register rising-edge detectors; a held level yields one event.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      div_q    <= 1'b0;
      div_prev <= 1'b0;
      ss_q     <= 1'b0;
      ss_prev  <= 1'b0;
      lap_q    <= 1'b0;
      lap_prev <= 1'b0;
    end else begin
      div_q    <= div_clk;
      div_prev <= div_q;
      ss_q     <= start_stop;
      ss_prev  <= ss_q;
      lap_q    <= lap;
      lap_prev <= lap_q;
    end
  end

  // State register.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; clear overrides any start/stop event.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ss_evt) state_nxt = RUN;
      RUN:     if (ss_evt) state_nxt = PAUSE;
      PAUSE:   if (ss_evt) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  // Counting uses the current state, so a tick during RUN->PAUSE still counts.
  assign en_chain[0] = (state == RUN) & tick & ~clear;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : gen_digit
    bcd_digit u_digit (
      .clk_in    (clk_in),
      .rst       (rst),
      .clr       (clear),
      .en        (en_chain[g]),
      .q         (count[g*DIGIT_W +: DIGIT_W]),
      .carry_out (en_chain[g+1])
    );
  end

  // Sticky overflow: set when the top digit carries out.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst)                       overflow <= 1'b0;
    else if (clear)                overflow <= 1'b0;
    else if (en_chain[NUM_DIGITS]) overflow <= 1'b1;
  end

  // Lap freeze: capture the pre-increment count when freezing in RUN.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      lap_active <= 1'b0;
      snapshot   <= '0;
    end else if (clear) begin
      lap_active <= 1'b0;
    end else if (lap_evt) begin
      if (lap_active) begin
        lap_active <= 1'b0;
      end else if (state == RUN) begin
        lap_active <= 1'b1;
        snapshot   <= count;
      end
    end
  end

  assign bcd_out = lap_active ? snapshot : count;
  assign running = (state == RUN);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

  localparam int N   = 4;
  localparam int MOD = 10000;

  logic           clk_in = 1'b0;
  logic           rst = 1'b1;
  logic           div_clk = 1'b0, start_stop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic [4*N-1:0] bcd_out;
  logic           running, lap_active, overflow;

  int n_checks = 0;
  int n_errors = 0;

  stopwatch_ctrl #(.NUM_DIGITS(N)) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .div_clk    (div_clk),
    .start_stop (start_stop),
    .clear      (clear),
    .lap        (lap),
    .bcd_out    (bcd_out),
    .running    (running),
    .lap_active (lap_active),
    .overflow   (overflow)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: integer count, flags, and the last two samples of each input.
  int m_cnt, m_snap, m_old;
  bit m_run, m_lap, m_ovf;
  bit m_dq, m_dp, m_sq, m_sp, m_lq, m_lp;
  bit m_tk, m_se, m_le;

  always @(posedge clk_in or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_snap = 0; m_run = 0; m_lap = 0; m_ovf = 0;
      m_dq = 0; m_dp = 0; m_sq = 0; m_sp = 0; m_lq = 0; m_lp = 0;
    end else begin
      m_tk = m_dq && !m_dp;
      m_se = m_sq && !m_sp;
      m_le = m_lq && !m_lp;
      if (clear) begin
        m_run = 0; m_cnt = 0; m_ovf = 0; m_lap = 0;
      end else begin
        m_old = m_cnt;
        if (m_run && m_tk) begin
          m_cnt = m_cnt + 1;
          if (m_cnt == MOD) begin
            m_cnt = 0;
            m_ovf = 1;
          end
        end
        if (m_le) begin
          if (m_lap) m_lap = 0;
          else if (m_run) begin
            m_snap = m_old;
            m_lap  = 1;
          end
        end
        if (m_se) m_run = !m_run;
      end
      m_dp = m_dq; m_dq = div_clk;
      m_sp = m_sq; m_sq = start_stop;
      m_lp = m_lq; m_lq = lap;
    end
  end

  function automatic logic [4*N-1:0] to_bcd(input int v);
    logic [4*N-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < N; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic div_tick(input int n);
    for (int i = 0; i < n; i++) begin
      div_clk = 1'b1; step();
      div_clk = 1'b0; step();
    end
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1; step();
    start_stop = 1'b0; step(); step();
  endtask

  task automatic pulse_lap();
    lap = 1'b1; step();
    lap = 1'b0; step(); step();
  endtask

  task automatic do_clear();
    clear = 1'b1; step();
    clear = 1'b0; step();
  endtask

  typedef struct {
    bit             clr;
    bit             ss;
    bit             lp;
    int             ticks;
    logic [4*N-1:0] bcd;
    bit             run;
    bit             lapa;
    bit             ovf;
  } row_t;

  row_t rows[9];

  initial begin
    rows[0] = '{0, 0, 0,  5, 16'h0000, 0, 0, 0}; // idle ignores ticks
    rows[1] = '{0, 1, 0,  7, 16'h0007, 1, 0, 0}; // start, count to 7
    rows[2] = '{0, 0, 1,  5, 16'h0007, 1, 1, 0}; // lap freezes display
    rows[3] = '{0, 0, 1,  0, 16'h0012, 1, 0, 0}; // unfreeze shows live count
    rows[4] = '{0, 1, 0,  4, 16'h0012, 0, 0, 0}; // pause holds
    rows[5] = '{0, 0, 1,  0, 16'h0012, 0, 0, 0}; // lap in pause ignored
    rows[6] = '{0, 1, 0,  3, 16'h0015, 1, 0, 0}; // resume
    rows[7] = '{1, 0, 0,  0, 16'h0000, 0, 0, 0}; // clear
    rows[8] = '{0, 1, 0, 12, 16'h0012, 1, 0, 0}; // restart with carry

    repeat (3) step();
    check("reset_bcd", 32'(bcd_out), 32'h0);
    check("reset_running", 32'(running), 32'h0);
    check("reset_ovf", 32'(overflow), 32'h0);
    check("reset_lap", 32'(lap_active), 32'h0);
    rst = 1'b0;
    step();

    for (int r = 0; r < 9; r++) begin
      if (rows[r].clr) do_clear();
      if (rows[r].ss)  pulse_ss();
      if (rows[r].lp)  pulse_lap();
      div_tick(rows[r].ticks);
      check($sformatf("row%0d_bcd", r), 32'(bcd_out), 32'(rows[r].bcd));
      check($sformatf("row%0d_running", r), 32'(running), 32'(rows[r].run));
      check($sformatf("row%0d_lap", r), 32'(lap_active), 32'(rows[r].lapa));
      check($sformatf("row%0d_ovf", r), 32'(overflow), 32'(rows[r].ovf));
    end

    // Tick latency: sampled high at edge k, count moves at k+1.
    div_clk = 1'b1; step();
    check("lat_pre", 32'(bcd_out), 32'h0012);
    div_clk = 1'b0; step();
    check("lat_post", 32'(bcd_out), 32'h0013);

    // Held button toggles once.
    start_stop = 1'b1;
    repeat (10) step();
    start_stop = 1'b0; step();
    check("held_pause", 32'(running), 32'h0);
    div_tick(4);
    check("pause_hold", 32'(bcd_out), 32'h0013);
    pulse_ss();
    check("resume_run", 32'(running), 32'h1);
    div_tick(2);
    check("resume_count", 32'(bcd_out), 32'h0015);

    // Tick coinciding with RUN->PAUSE counts.
    div_clk = 1'b1; start_stop = 1'b1; step();
    div_clk = 1'b0; start_stop = 1'b0; step(); step();
    check("stop_tick_bcd", 32'(bcd_out), 32'h0016);
    check("stop_tick_running", 32'(running), 32'h0);

    // Tick coinciding with PAUSE->RUN does not count.
    div_clk = 1'b1; start_stop = 1'b1; step();
    div_clk = 1'b0; start_stop = 1'b0; step(); step();
    check("go_tick_bcd", 32'(bcd_out), 32'h0016);
    check("go_tick_running", 32'(running), 32'h1);

    // Clear beats tick and start/stop in the same cycle.
    div_clk = 1'b1; start_stop = 1'b1; step();
    clear = 1'b1; step();
    clear = 1'b0; div_clk = 1'b0; start_stop = 1'b0; step(); step();
    check("prio_bcd", 32'(bcd_out), 32'h0000);
    check("prio_running", 32'(running), 32'h0);

    // Asynchronous reset mid-count with the display frozen.
    pulse_ss();
    div_tick(3);
    pulse_lap();
    check("pre_rst_lap", 32'(lap_active), 32'h1);
    rst = 1'b1;
    #2;
    check("async_bcd", 32'(bcd_out), 32'h0);
    check("async_running", 32'(running), 32'h0);
    check("async_lap", 32'(lap_active), 32'h0);
    check("async_ovf", 32'(overflow), 32'h0);
    div_tick(2);
    rst = 1'b0;
    step();
    div_tick(5);
    check("idle_after_rst", 32'(bcd_out), 32'h0000);

    // Wrap past all nines.
    pulse_ss();
    div_tick(9998);
    check("wrap_9998", 32'(bcd_out), 32'h9998);
    div_tick(1);
    check("wrap_9999", 32'(bcd_out), 32'h9999);
    check("wrap_ovf_pre", 32'(overflow), 32'h0);
    div_tick(1);
    check("wrap_0000", 32'(bcd_out), 32'h0000);
    check("wrap_ovf", 32'(overflow), 32'h1);
    div_tick(3);
    check("wrap_sticky", 32'(overflow), 32'h1);
    check("wrap_0003", 32'(bcd_out), 32'h0003);
    do_clear();
    check("clr_ovf", 32'(overflow), 32'h0);
    check("clr_running", 32'(running), 32'h0);
    check("clr_bcd", 32'(bcd_out), 32'h0000);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      div_clk    = 1'($urandom_range(0, 1));
      start_stop = ($urandom_range(0, 7) == 0);
      lap        = ($urandom_range(0, 9) == 0);
      clear      = ($urandom_range(0, 199) == 0);
      step();
      check("rand_bcd", 32'(bcd_out), 32'(to_bcd(m_lap ? m_snap : m_cnt)));
      check("rand_running", 32'(running), 32'(m_run));
      check("rand_lap", 32'(lap_active), 32'(m_lap));
      check("rand_ovf", 32'(overflow), 32'(m_ovf));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Downstream consumer of clk_div.
- Samples the divided clock (clk_div.clk_out) as data in the clk_in domain and turns each rising edge into a one-cycle tick.
- Runs a start/stop/pause/lap-controlled cascaded BCD counter from those ticks.
- bcd_out feeds the display stage; the whole block stays on a single clock.

Parameters:
- NUM_DIGITS, 4: number of cascaded decimal digits (range 1..8).

Ports:
- clk_in  input  1  system clock, the same clock that drives clk_div.
- rst  input  1  asynchronous reset, active-high.
- div_clk  input  1  clk_div.clk_out, treated as a synchronous data level.
- start_stop  input  1  button level; its rising edge toggles run/pause.
- clear  input  1  level; synchronous clear, highest priority.
- lap  input  1  button level; its rising edge toggles display freeze.
- bcd_out  output  4*NUM_DIGITS  displayed digits; digit 0 is in bits [3:0] (least significant).
- running  output  1  high when state is RUN.
- lap_active  output  1  high while the display is frozen.
- overflow  output  1  sticky flag; set when the count wraps past all nines.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; count=0; snapshot=0; bcd_out=0; running=0; lap_active=0; overflow=0; all edge-detect registers=0.
- Edge detect: div_q <= div_clk; div_prev <= div_q; tick = div_q & ~div_prev.
  - start_stop and lap use identical two-register detectors.
  - A level held high produces exactly one event.
- Latency: div_clk rises before clk_in edge k -> tick is high between k and k+1 -> count updates at k+1. bcd_out reflects the new count at k+1 (combinational from count when not frozen).
- States: IDLE, RUN, PAUSE.
  - IDLE --start_stop evt--> RUN.
  - RUN --start_stop evt--> PAUSE.
  - PAUSE --start_stop evt--> RUN.
  - Any state with clear=1 -> IDLE; count=0, overflow=0, lap_active=0.
- Counting: increment only when the current state is RUN and tick=1.
  - Digit i increments when every lower digit is 9; a digit at 9 that increments goes to 0 and carries.
  - All digits at 9 plus a tick -> all digits 0 and overflow <= 1. overflow stays 1 until clear or rst.
  - BCD digit values never exceed 9.
- Lap:
  - lap event in RUN with lap_active=0: snapshot <= count (the pre-increment value if a tick lands in the same cycle); lap_active <= 1.
  - lap event with lap_active=1, in any state: lap_active <= 0.
  - lap event in IDLE or PAUSE with lap_active=0: ignored.
  - bcd_out = lap_active ? snapshot : count. The count keeps running while frozen.
- Simultaneous events:
  - clear beats everything, including tick, start_stop and lap.
  - A tick in the same cycle as RUN->PAUSE is counted, because the current state is used.
  - A tick in the same cycle as IDLE/PAUSE->RUN is not counted.
  - start_stop and lap events in the same cycle are both applied.
- rst asserted mid-count: every output returns to its reset value immediately, without waiting for a clock edge.

Decomposition:
- Package stopwatch_pkg:
  - state encoding: IDLE=2'b00, RUN=2'b01, PAUSE=2'b10; 2'b11 is illegal and recovers to IDLE.
  - constant BCD_MAX=4'd9.
  - digit width constant 4.
- Sub-module bcd_digit: one decade counter.
  - Inputs: clk_in, rst, clr, en.
  - Outputs: q[3:0], carry_out = en & (q==9).
  - stopwatch_ctrl instantiates NUM_DIGITS of them via a generate loop with a chained enable.

Test Plan:
1. Reset and idle: assert rst mid-sim with div_clk toggling -> bcd_out=0x0000, running=0, overflow=0. With no start_stop, 5 div_clk rises leave bcd_out=0x0000.
2. Run and carry: start_stop pulse, then 12 div_clk rising edges -> bcd_out=0x0012, running=1. Each increment lands one clk_in cycle after div_clk is sampled high.
3. Pause/resume and held button: start_stop held high for 10 cycles -> exactly one RUN->PAUSE transition. 4 ticks during PAUSE -> the count holds. A second pulse resumes counting.
4. Wrap: preload to 0x9998 by running 9998 ticks, then 2 more ticks -> bcd_out=0x9999, then 0x0000 with overflow=1. overflow stays 1 after 3 further ticks; clear -> overflow=0, state IDLE.
5. Lap: at count 0x0007 pulse lap, then 5 ticks -> bcd_out stays 0x0007 with lap_active=1. Second lap pulse -> bcd_out=0x0012.
6. Priority: clear, tick and start_stop in the same cycle from RUN -> state IDLE and count 0x0000. A tick in the same cycle as the RUN->PAUSE pulse is counted (+1).
